// File: rtl/network_mac_acc_26s_16s.sv
// network_mac_acc_26s_16s
//   Accumulate/requantize stage of the convolution datapath. Sums one kernel
//   window of signed products plus a scaled bias, then rounds (half up),
//   arithmetic-shifts by FRAC_SHIFT and saturates to a signed OUT_WIDTH
//   activation. One result per window, ready/valid on both sides.
//
//   Optional feature macro: NETWORK_MAC_RELU_EN
//     defined   -> negative saturated results are clamped to 0
//     undefined -> signed saturated result passed unchanged
//
// Ports:
//   clk          in   clock, all state on rising edge
//   reset_n      in   asynchronous active-low reset
//   prod_valid   in   product beat valid
//   prod_ready   out  stage can accept a beat (~out_valid | out_ready)
//   prod_data    in   signed product, PROD_WIDTH
//   prod_last    in   beat is the final tap of the window
//   bias         in   signed bias, sampled on the first beat of a window
//   out_valid    out  activation available
//   out_ready    in   consumer accepts activation
//   out_data     out  signed activation, OUT_WIDTH
//   err_overrun  out  sticky: a window exceeded MAX_TAPS beats
module network_mac_acc_26s_16s #(
  parameter int PROD_WIDTH = 26,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 9,
  parameter int MAX_TAPS   = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  input  logic [PROD_WIDTH-1:0] prod_data,
  input  logic                  prod_last,
  input  logic [OUT_WIDTH-1:0]  bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  err_overrun
);

  localparam int TAP_W = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;

  // Rounding constant and saturation bounds, all ACC_WIDTH+1 wide so the
  // rounding add cannot wrap.
  localparam logic signed [ACC_WIDTH:0] HALF =
    {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] OUT_MAX =
    {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN =
    {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t                       state, state_next;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic [TAP_W-1:0]             tap_cnt;

  logic                         accept;
  logic                         take;
  logic                         overrun_hit;
  logic                         finish;
  logic signed [ACC_WIDTH-1:0]  bias_ext;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  base;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [ACC_WIDTH:0]    rnd;
  logic signed [ACC_WIDTH:0]    shifted;
  logic [OUT_WIDTH-1:0]         sat;
  logic [OUT_WIDTH-1:0]         result;

  assign prod_ready = ~out_valid | out_ready;
  assign accept     = prod_valid & prod_ready;
  assign take       = out_valid & out_ready;

  assign bias_ext = {{(ACC_WIDTH - OUT_WIDTH){bias[OUT_WIDTH-1]}}, bias};
  assign prod_ext = {{(ACC_WIDTH - PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};

  // First beat of a window seeds the sum with the bias in the same fixed-point
  // scale as the products; later beats extend the running sum.
  assign base = (state == IDLE) ? (bias_ext <<< FRAC_SHIFT) : acc;
  assign sum  = base + prod_ext;

  // A window that reaches MAX_TAPS beats without prod_last is closed here.
  assign overrun_hit = accept & ~prod_last & (tap_cnt == TAP_W'(MAX_TAPS - 1));
  assign finish      = accept & (prod_last | overrun_hit);

  assign rnd     = {sum[ACC_WIDTH-1], sum} + HALF;
  assign shifted = rnd >>> FRAC_SHIFT;

  always_comb begin
    sat = shifted[OUT_WIDTH-1:0];
    if (shifted > OUT_MAX) begin
      sat = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    end else if (shifted < OUT_MIN) begin
      sat = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
    end
    result = sat;
`ifdef NETWORK_MAC_RELU_EN
    if (sat[OUT_WIDTH-1]) begin
      result = '0;
    end
`endif
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = finish ? IDLE : ACCUM;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      acc         <= '0;
      tap_cnt     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      err_overrun <= 1'b0;
    end else begin
      state <= state_next;

      if (accept) begin
        if (finish) begin
          acc     <= '0;
          tap_cnt <= '0;
        end else begin
          acc     <= sum;
          tap_cnt <= tap_cnt + TAP_W'(1);
        end
      end

      // A new result wins over a same-cycle take, giving back-to-back output.
      if (finish) begin
        out_valid <= 1'b1;
        out_data  <= result;
      end else if (take) begin
        out_valid <= 1'b0;
      end

      if (overrun_hit) begin
        err_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_network_mac_acc_26s_16s.sv
// Directed-vector bench for network_mac_acc_26s_16s (default parameters).
module tb_network_mac_acc_26s_16s;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               prod_valid;
  logic               prod_ready;
  logic [25:0]        prod_data;
  logic               prod_last;
  logic [15:0]        bias;
  logic               out_valid;
  logic               out_ready;
  logic [15:0]        out_data;
  logic               err_overrun;

  int errors = 0;
  int checks = 0;
  int take_cnt = 0;

  network_mac_acc_26s_16s #(
    .PROD_WIDTH(26),
    .ACC_WIDTH (32),
    .OUT_WIDTH (16),
    .FRAC_SHIFT(9),
    .MAX_TAPS  (64)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod_data  (prod_data),
    .prod_last  (prod_last),
    .bias       (bias),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid && out_ready) take_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Presents one beat for exactly one rising edge; returns 1 time unit after it.
  task automatic send(input int d, input logic l, input int b);
    prod_data  = 26'(d);
    prod_last  = l;
    bias       = 16'(b);
    prod_valid = 1'b1;
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    prod_valid = 1'b0;
    prod_data  = 26'h3FFFFFF;
    prod_last  = 1'b0;
    bias       = 16'h1234;
    out_ready  = 1'b1;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_overrun); end
    checks++; if (prod_ready !== 1'b1) begin errors++; $display("FAIL reset_prod_ready got=%b exp=1", prod_ready); end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(512, 1'b0, 0);
    send(512, 1'b0, 99);   // bias ignored after the first beat
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_mid_valid got=%b exp=0", out_valid); end
    send(512, 1'b1, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 16'd3) begin errors++; $display("FAIL basic_data got=%0d exp=3", $signed(out_data)); end
    idle_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_rounding();
    int          prods[4];
    logic [15:0] exp_v[4];
    prods = '{256, 255, -256, -257};
    exp_v = '{16'd1, 16'd0, 16'd0, 16'hFFFF};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(prods[i], 1'b1, 0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL round_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (out_data !== exp_v[i]) begin errors++; $display("FAIL round_data[%0d] got=%0d exp=%0d", i, $signed(out_data), $signed(exp_v[i])); end
    end
    idle_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL round_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_bias_sat();
    logic [15:0] exp_neg;
    out_ready = 1'b1;
    send(0, 1'b1, 5);
    checks++; if (out_data !== 16'd5) begin errors++; $display("FAIL bias_only got=%0d exp=5", $signed(out_data)); end
    for (int i = 0; i < 4; i++) send(1 << 24, (i == 3), 0);
    checks++; if (out_data !== 16'h7FFF) begin errors++; $display("FAIL sat_pos got=%0d exp=32767", $signed(out_data)); end
`ifdef NETWORK_MAC_RELU_EN
    exp_neg = 16'h0000;
`else
    exp_neg = 16'h8000;
`endif
    send(-(1 << 25), 1'b1, -32768);
    checks++; if (out_data !== exp_neg) begin errors++; $display("FAIL sat_neg got=%0d exp=%0d", $signed(out_data), $signed(exp_neg)); end
    idle_cycle();
  endtask

  task automatic test_backpressure();
    int takes0;
    out_ready = 1'b1;
    takes0 = take_cnt;
    out_ready = 1'b0;
    send(1024, 1'b1, 0);
    checks++; if (out_data !== 16'd2) begin errors++; $display("FAIL bp_first got=%0d exp=2", $signed(out_data)); end
    // Offer a beat that must not be accepted while the result is held.
    prod_data  = 26'd512;
    prod_last  = 1'b1;
    bias       = 16'd0;
    prod_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (prod_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, prod_ready); end
      idle_cycle();
      checks++; if (out_valid !== 1'b1 || out_data !== 16'd2) begin errors++; $display("FAIL bp_hold[%0d] got=%b/%0d exp=1/2", i, out_valid, $signed(out_data)); end
    end
    out_ready = 1'b1;
    idle_cycle();
    prod_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'd1) begin errors++; $display("FAIL bp_replace got=%b/%0d exp=1/1", out_valid, $signed(out_data)); end
    idle_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    checks++; if (take_cnt - takes0 !== 2) begin errors++; $display("FAIL bp_takes got=%0d exp=2", take_cnt - takes0); end
  endtask

  task automatic test_overrun();
    out_ready = 1'b1;
    for (int i = 0; i < 63; i++) send(1, 1'b0, 0);
    checks++; if (out_valid !== 1'b0 || err_overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre got=%b/%b exp=0/0", out_valid, err_overrun); end
    send(1, 1'b0, 0);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'd0) begin errors++; $display("FAIL ovr_emit got=%b/%0d exp=1/0", out_valid, $signed(out_data)); end
    checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", err_overrun); end
    send(512, 1'b1, 0);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'd1) begin errors++; $display("FAIL ovr_next got=%b/%0d exp=1/1", out_valid, $signed(out_data)); end
    checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", err_overrun); end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(512, 1'b1, 3);       // held result: (1536+512+256)>>9 = 4
    checks++; if (out_valid !== 1'b1 || out_data !== 16'd4) begin errors++; $display("FAIL rst_held got=%b/%0d exp=1/4", out_valid, $signed(out_data)); end
    out_ready = 1'b1;
    idle_cycle();
    for (int i = 0; i < 3; i++) send(4096, 1'b0, 7);
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 16'd0) begin errors++; $display("FAIL rst_async_out got=%b/%0d exp=0/0", out_valid, $signed(out_data)); end
    checks++; if (err_overrun !== 1'b0 || prod_ready !== 1'b1) begin errors++; $display("FAIL rst_async_flags got=%b/%b exp=0/1", err_overrun, prod_ready); end
    #2;
    reset_n = 1'b1;
    send(1024, 1'b1, 0);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'd2) begin errors++; $display("FAIL rst_after got=%b/%0d exp=1/2", out_valid, $signed(out_data)); end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_bias_sat();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/network_mac_acc_26s_16s.md
# network_mac_acc_26s_16s

Downstream accumulate/requantize stage for the convolution datapath. It consumes the signed 26-bit products of the 16s×10s DSP multiplier stage and sums one kernel window of products plus a bias. It then rounds, shifts and saturates the sum back to a signed 16-bit activation for the next layer. One output is produced per kernel window, with a ready/valid handshake on both sides.

## Interface
- PROD_WIDTH, 26, product width (signed)
- ACC_WIDTH, 32, accumulator width (signed)
- OUT_WIDTH, 16, activation/bias width (signed)
- FRAC_SHIFT, 9, right shift applied to the sum; must be ≥1
- MAX_TAPS, 64, maximum products per window; ACC_WIDTH must hold MAX_TAPS·2^(PROD_WIDTH-1) + bias
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- prod_valid  in  1  product beat valid
- prod_ready  out  1  stage can accept a beat
- prod_data  in  PROD_WIDTH  signed product
- prod_last  in  1  beat is the final tap of the window
- bias  in  OUT_WIDTH  signed bias, sampled on the first beat of a window
- out_valid  out  1  activation available
- out_ready  in  1  consumer accepts activation
- out_data  out  OUT_WIDTH  signed activation
- err_overrun  out  1  sticky: window exceeded MAX_TAPS

## Operation
- Beat accepted = prod_valid & prod_ready. Output taken = out_valid & out_ready.
- prod_ready = ~out_valid | out_ready (combinational). The stage stalls only while an unconsumed result is held.
- States: IDLE (no window open) and ACCUM (window open).
- IDLE + accepted beat:
  - acc ← sext(bias)·2^FRAC_SHIFT + sext(prod_data); tap_cnt ← 1.
  - Go to ACCUM, unless prod_last is set.
- ACCUM + accepted beat: acc ← acc + sext(prod_data); tap_cnt ← tap_cnt+1.
- Any accepted beat with prod_last=1 (including a single-beat window straight from IDLE):
  - Final sum s = the updated acc value.
  - r = (s + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT (round half up, arithmetic shift).
  - out_data ← r saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - out_valid ← 1; acc ← 0; tap_cnt ← 0; state ← IDLE.
- Overrun: a non-last beat accepted when tap_cnt = MAX_TAPS-1 forces the result to be emitted as if prod_last had been set, and sets err_overrun. The next beat starts a new window. err_overrun is cleared only by reset.
- Output taken with no new last beat: out_valid ← 0.
- Same cycle as output taken and a new last beat accepted: out_valid stays 1 and out_data takes the new result. No bubble, no loss.
- out_data is held stable while out_valid & ~out_ready.

## Timing
- Reset values: out_valid=0, out_data=0, err_overrun=0, acc=0, tap_cnt=0, state=IDLE. prod_ready=1 after reset.
- Latency: last beat accepted at edge N → out_valid=1 with the result after edge N.
- Throughput: one beat per cycle sustained, including back-to-back single-tap windows, provided out_ready=1.
- reset_n asserted mid-window discards the partial sum and any held output immediately (asynchronous). Nothing is emitted for that window.
- prod_data and bias are ignored when the beat is not accepted.

## Configuration
- NETWORK_MAC_RELU_EN defined: after saturation, negative results are clamped to 0, so out_data ∈ [0, 32767].
- NETWORK_MAC_RELU_EN undefined: the signed saturated result is passed unchanged.
- Rounding, saturation and handshake behaviour are identical in both builds.

## Test plan
- Defaults, bias=0, beats 512, 512, 512(last), out_ready=1 → one cycle after the last beat: out_valid=1, out_data=3; then out_valid=0.
- Rounding, single-beat windows with bias=0:
  - prod 256 → 1
  - prod 255 → 0
  - prod -256 → 0
  - prod -257 → -1
  - All four issued back-to-back → four consecutive out_valid cycles.
- Bias and saturation:
  - bias=5, prod 0(last) → 5.
  - bias=0, four beats of 2^24 → 32767.
  - bias=-32768, prod -2^25(last) → -32768 without NETWORK_MAC_RELU_EN; 0 with it.
- Backpressure:
  - out_ready=0 after a result → prod_ready=0, out_data held for 5 cycles.
  - Raise out_ready in the same cycle as a new last beat → new result replaces the old one with no gap, and both are observed once.
- Overrun: 64 non-last beats of 1, bias=0 → result (64+256)>>9 = 0 emitted after beat 64, err_overrun=1. The next window of a single beat 512 → 1, and err_overrun stays 1.
- reset_n pulsed low after 3 of 5 beats → all outputs return to reset values at once. A following window of a single beat 1024 → 2, unaffected by the discarded partial sum.
